// File: rtl/jk_reg_bank.sv
// jk_reg_bank
//   Bank of WIDTH independent JK flip-flops on one clock. Priority at each
//   rising edge is reset > load > en > hold. Per-bit change flags and a
//   saturating change-event counter track activity on Q.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   en       in   1      clock enable for the JK update
//   load     in   1      parallel load strobe (overrides en/J/K)
//   d        in   WIDTH  parallel load data
//   J, K     in   WIDTH  per-bit JK inputs
//   cnt_clr  in   1      synchronous clear of chg_cnt
//   Q        out  WIDTH  registered state
//   Qb       out  WIDTH  complement of Q (combinational)
//   toggled  out  WIDTH  bits of Q that changed at the last edge
//   chg_cnt  out  CNT_W  saturating count of edges at which Q changed
module jk_reg_bank #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic [WIDTH-1:0] toggled,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Classic JK characteristic for one bit.
  function automatic logic jk_bit(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

  // Next-state selection for Q: load beats the JK update, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_d[i] = jk_bit(q_q[i], J[i], K[i]);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Change flags and counter; clear wins over a simultaneous change and
  // the counter sticks at its maximum instead of wrapping.
  always_comb begin
    tog_d = q_d ^ q_q;
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((q_d != q_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      tog_q <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      q_q   <= q_d;
      tog_q <= tog_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q       = q_q;
  assign Qb      = ~q_q;
  assign toggled = tog_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with WIDTH=4, RESET_VAL=4'b1010, CNT_W=3.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       reset, en, load, cnt_clr;
  logic [3:0] d, J, K;
  logic [3:0] Q, Qb, toggled;
  logic [2:0] chg_cnt;

  int n_cmp = 0;
  int n_err = 0;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d),
    .J(J), .K(K), .cnt_clr(cnt_clr),
    .Q(Q), .Qb(Qb), .toggled(toggled), .chg_cnt(chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq,
                         input logic [3:0] et, input logic [2:0] ec);
    chk({tag, ".Q"},   {4'h0, Q},       {4'h0, eq});
    chk({tag, ".Qb"},  {4'h0, Qb},      {4'h0, ~eq});
    chk({tag, ".tog"}, {4'h0, toggled}, {4'h0, et});
    chk({tag, ".cnt"}, {5'h0, chg_cnt}, {5'h0, ec});
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; d = 4'hF; en = 1'b0;
    J = 4'h0; K = 4'h0; cnt_clr = 1'b0;
    #2;
    step(); chk_all("reset_with_load", 4'b1010, 4'b0000, 3'd0);

    reset = 1'b0; load = 1'b0; en = 1'b0;
    step(); chk_all("hold1", 4'b1010, 4'b0000, 3'd0);
    step(); chk_all("hold2", 4'b1010, 4'b0000, 3'd0);

    en = 1'b1; J = 4'b0101; K = 4'b1010;
    step(); chk_all("set_reset", 4'b0101, 4'b1111, 3'd1);
    J = 4'b0000; K = 4'b0000;
    step(); chk_all("jk_hold", 4'b0101, 4'b0000, 3'd1);

    J = 4'b0011; K = 4'b0011;
    step(); chk_all("tgl1", 4'b0110, 4'b0011, 3'd2);
    step(); chk_all("tgl2", 4'b0101, 4'b0011, 3'd3);
    step(); chk_all("tgl3", 4'b0110, 4'b0011, 3'd4);
    step(); chk_all("tgl4", 4'b0101, 4'b0011, 3'd5);
    step(); chk_all("tgl5", 4'b0110, 4'b0011, 3'd6);
    step(); chk_all("tgl6", 4'b0101, 4'b0011, 3'd7);
    step(); chk_all("sat1", 4'b0110, 4'b0011, 3'd7);
    step(); chk_all("sat2", 4'b0101, 4'b0011, 3'd7);

    cnt_clr = 1'b1;
    step(); chk_all("clr_tgl", 4'b0110, 4'b0011, 3'd0);
    cnt_clr = 1'b0;

    load = 1'b1; J = 4'hF; K = 4'hF; d = 4'b1100;
    step(); chk_all("load", 4'b1100, 4'b1010, 3'd1);
    step(); chk_all("load_same", 4'b1100, 4'b0000, 3'd1);
    load = 1'b0; en = 1'b0; K = 4'h0;
    step(); chk_all("en_off", 4'b1100, 4'b0000, 3'd1);

    en = 1'b1; K = 4'hF;
    step(); chk_all("tgl_all", 4'b0011, 4'b1111, 3'd2);
    reset = 1'b1;
    step(); chk_all("mid_reset", 4'b1010, 4'b0000, 3'd0);
    reset = 1'b0;
    step(); chk_all("post_reset", 4'b0101, 4'b1111, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
